cpu_axi_arbiter: RTL and testbench

Two-requester AXI master front-end for the pipelined CPU. It sits between instruction fetch (IF, read-only) and load/store (LS, read/write) on one side, and the single shared AXI memory slave on the other. It grants one transaction at a time (round-robin), drives the AXI channels, and returns a one-cycle response pulse to the owner. The slave ID inputs are tied to 0 at the top level.

---
 rtl/cpu_axi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cpu_axi_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_arbiter.sv
// Round-robin two-requester (IF read-only, LS read/write) front-end onto a single AXI slave.
// Define AXI_ARB_LS_PRIO_EN to give LS fixed priority over IF instead of round-robin.
module cpu_axi_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [STRB_W-1:0] ls_req_wstrb,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [DATA_W-1:0] axi_w_data,
  output logic [STRB_W-1:0] axi_w_strb,
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic              axi_r_valid,
  output logic              axi_r_ready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  state_e            state, state_nxt;
  owner_e            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              grant_if, grant_ls;

`ifndef AXI_ARB_LS_PRIO_EN
  owner_e            last_grant;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE && !rst) begin
`ifdef AXI_ARB_LS_PRIO_EN
      grant_ls = ls_req_valid;
      grant_if = if_req_valid && !ls_req_valid;
`else
      if (if_req_valid && ls_req_valid) begin
        grant_if = (last_grant == OWN_LS);
        grant_ls = (last_grant == OWN_IF);
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
`endif
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    state_nxt    = state;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ls && ls_req_we)   state_nxt = WR_REQ;
        else if (grant_if || grant_ls) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) state_nxt = IDLE;
      end
      WR_REQ: begin
        axi_aw_valid = 1'b1;
        axi_w_valid  = 1'b1;
        // Both channels advance together; the slave readies them jointly.
        if (axi_aw_ready && axi_w_ready) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign axi_ar_addr = addr_q;
  assign axi_aw_addr = addr_q;
  assign axi_w_data  = wdata_q;
  assign axi_w_strb  = wstrb_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_rdata <= '0;
`ifndef AXI_ARB_LS_PRIO_EN
      last_grant   <= OWN_LS;
`endif
    end else begin
      state        <= state_nxt;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (grant_if || grant_ls) begin
        addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
        wdata_q <= ls_req_wdata;
        wstrb_q <= ls_req_wstrb;
        owner   <= grant_ls ? OWN_LS : OWN_IF;
`ifndef AXI_ARB_LS_PRIO_EN
        last_grant <= grant_ls ? OWN_LS : OWN_IF;
`endif
      end
      if (state == RD_DATA && axi_r_valid) begin
        if (owner == OWN_IF) begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= axi_r_data;
        end else begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_rdata <= axi_r_data;
        end
      end
      if (state == WR_RESP && axi_b_valid) begin
        ls_rsp_valid <= 1'b1;
        ls_rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed bench for cpu_axi_arbiter: reactive AXI slave, transaction-level model checked every cycle,
// plus literal latency/data/grant-order expectations.
module tb_cpu_axi_arbiter;

  logic        clk, rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
  logic [7:0]  ls_req_wstrb;
  logic [63:0] axi_aw_addr, axi_w_data, axi_ar_addr, axi_r_data;
  logic [7:0]  axi_w_strb;
  logic        axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_b_valid, axi_b_ready;
  logic        axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready;

  cpu_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_valid(axi_w_valid),
    .axi_w_ready(axi_w_ready), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI slave: 16-word memory, programmable ar/r delays ----------------
  logic [63:0] mem [16];
  int          ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
  logic        rd_pend = 1'b0, b_pend = 1'b0;
  logic [63:0] rd_buf;

  assign axi_ar_ready = axi_ar_valid && (ar_wait >= ar_delay);
  assign axi_r_valid  = rd_pend && (r_wait >= r_delay);
  assign axi_r_data   = axi_r_valid ? rd_buf : 64'h0;
  assign axi_aw_ready = axi_aw_valid && axi_w_valid;
  assign axi_w_ready  = axi_aw_valid && axi_w_valid;
  assign axi_b_valid  = b_pend;

  always @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      b_pend  <= 1'b0;
      ar_wait <= 0;
      r_wait  <= 0;
      rd_buf  <= 64'h0;
      for (int i = 0; i < 16; i++) mem[i] <= {56'hA5A5_A5A5_A5A5_A5, 4'h0, 4'(i)};
      mem[0] <= 64'h1122_3344_5566_7788;
      mem[2] <= 64'hAAAA_AAAA_5555_5555;
    end else begin
      if (axi_ar_valid && axi_ar_ready) begin
        rd_pend <= 1'b1;
        rd_buf  <= mem[axi_ar_addr[6:3]];
        r_wait  <= 0;
        ar_wait <= 0;
      end else if (axi_ar_valid) begin
        ar_wait <= ar_wait + 1;
      end
      if (axi_r_valid && axi_r_ready) rd_pend <= 1'b0;
      else if (rd_pend)               r_wait  <= r_wait + 1;
      if (axi_aw_valid && axi_w_valid) begin
        for (int i = 0; i < 8; i++)
          if (axi_w_strb[i]) mem[axi_aw_addr[6:3]][8*i +: 8] <= axi_w_data[8*i +: 8];
        b_pend <= 1'b1;
      end
      if (b_pend && axi_b_ready) b_pend <= 1'b0;
    end
  end

  // ---------------- Transaction-level model + per-cycle compare ----------------
  int          cyc = 0;
  logic        m_busy = 1'b0, a_done = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_last = 1'b1;
  logic [63:0] m_addr = 64'h0, m_wdata = 64'h0;
  logic [7:0]  m_wstrb = 8'h0;
  logic        pend_v = 1'b0, pend_owner = 1'b0;
  int          pend_cyc = 0;
  logic [63:0] pend_data = 64'h0, exp_if_data = 64'h0, exp_ls_data = 64'h0;

  // Event log consulted by the directed checks.
  logic        grant_log [$];
  int          if_ready_cnt = 0, ls_ready_cnt = 0, if_rsp_cnt = 0, ls_rsp_cnt = 0;
  int          if_ready_cyc = 0, ls_ready_cyc = 0, if_rsp_cyc = 0, ls_rsp_cyc = 0;
  int          ar_rise_cyc = 0, aw_rise_cyc = 0, w_rise_cyc = 0;
  logic        prev_ar = 1'b0, prev_aw = 1'b0, prev_w = 1'b0;
  logic [63:0] last_if_data = 64'h0, last_ls_data = 64'h0;

  always @(negedge clk) begin
    logic g_if, g_ls, e_rd_a, e_rd_d, e_wr_a, e_wr_b, rsp_if, rsp_ls;
    cyc++;
    rsp_if = pend_v && (pend_cyc == cyc) && !pend_owner;
    rsp_ls = pend_v && (pend_cyc == cyc) && pend_owner;
    if (rsp_if) exp_if_data = pend_data;
    if (rsp_ls) exp_ls_data = pend_data;

    g_if = 1'b0;
    g_ls = 1'b0;
    if (!rst && !m_busy) begin
`ifdef AXI_ARB_LS_PRIO_EN
      g_ls = ls_req_valid;
      g_if = if_req_valid && !ls_req_valid;
`else
      if (if_req_valid && ls_req_valid) begin
        g_if = m_last;
        g_ls = !m_last;
      end else begin
        g_if = if_req_valid;
        g_ls = ls_req_valid;
      end
`endif
    end
    e_rd_a = m_busy && !m_wr && !a_done;
    e_rd_d = m_busy && !m_wr && a_done;
    e_wr_a = m_busy && m_wr && !a_done;
    e_wr_b = m_busy && m_wr && a_done;

    check("if_req_ready", 64'(if_req_ready), 64'(g_if));
    check("ls_req_ready", 64'(ls_req_ready), 64'(g_ls));
    check("axi_ar_valid", 64'(axi_ar_valid), 64'(e_rd_a));
    check("axi_r_ready",  64'(axi_r_ready),  64'(e_rd_d));
    check("axi_aw_valid", 64'(axi_aw_valid), 64'(e_wr_a));
    check("axi_w_valid",  64'(axi_w_valid),  64'(e_wr_a));
    check("axi_b_ready",  64'(axi_b_ready),  64'(e_wr_b));
    if (e_rd_a) check("axi_ar_addr", axi_ar_addr, m_addr);
    if (e_wr_a) begin
      check("axi_aw_addr", axi_aw_addr, m_addr);
      check("axi_w_data",  axi_w_data,  m_wdata);
      check("axi_w_strb",  64'(axi_w_strb), 64'(m_wstrb));
    end
    check("if_rsp_valid", 64'(if_rsp_valid), 64'(rsp_if));
    check("ls_rsp_valid", 64'(ls_rsp_valid), 64'(rsp_ls));
    check("if_rsp_data",  if_rsp_data,  exp_if_data);
    check("ls_rsp_rdata", ls_rsp_rdata, exp_ls_data);
    if (rsp_if || rsp_ls) pend_v = 1'b0;

    if (if_req_ready) begin grant_log.push_back(1'b0); if_ready_cnt++; if_ready_cyc = cyc; end
    if (ls_req_ready) begin grant_log.push_back(1'b1); ls_ready_cnt++; ls_ready_cyc = cyc; end
    if (if_rsp_valid) begin if_rsp_cnt++; if_rsp_cyc = cyc; last_if_data = if_rsp_data; end
    if (ls_rsp_valid) begin ls_rsp_cnt++; ls_rsp_cyc = cyc; last_ls_data = ls_rsp_rdata; end
    if (axi_ar_valid && !prev_ar) ar_rise_cyc = cyc;
    if (axi_aw_valid && !prev_aw) aw_rise_cyc = cyc;
    if (axi_w_valid  && !prev_w)  w_rise_cyc  = cyc;
    prev_ar = axi_ar_valid;
    prev_aw = axi_aw_valid;
    prev_w  = axi_w_valid;

    if (rst) begin
      m_busy = 1'b0; a_done = 1'b0; m_last = 1'b1; pend_v = 1'b0;
      exp_if_data = 64'h0; exp_ls_data = 64'h0;
    end else if (m_busy) begin
      if (!a_done) begin
        if (m_wr ? (axi_aw_ready && axi_w_ready) : axi_ar_ready) a_done = 1'b1;
      end else if (m_wr ? axi_b_valid : axi_r_valid) begin
        m_busy     = 1'b0;
        pend_v     = 1'b1;
        pend_cyc   = cyc + 1;
        pend_owner = m_own;
        pend_data  = m_wr ? 64'h0 : axi_r_data;
      end
    end else if (g_if || g_ls) begin
      m_busy  = 1'b1;
      a_done  = 1'b0;
      m_own   = g_ls;
      m_wr    = g_ls && ls_req_we;
      m_addr  = g_ls ? ls_req_addr : if_req_addr;
      m_wdata = ls_req_wdata;
      m_wstrb = ls_req_wstrb;
      m_last  = g_ls;
    end
  end

  // ---------------- Drivers (inputs change 1 time unit after posedge) ----------------
  task automatic req_if(input logic [63:0] a);
    int n0 = if_ready_cnt;
    int t = 0;
    if_req_addr  = a;
    if_req_valid = 1'b1;
    while (if_ready_cnt == n0 && t < 100) begin @(posedge clk); #1; t++; end
    if (if_ready_cnt == n0) check("if_ready_timeout", 64'(0), 64'(1));
    if_req_valid = 1'b0;
  endtask

  task automatic req_ls(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n0 = ls_ready_cnt;
    int t = 0;
    ls_req_we = we; ls_req_addr = a; ls_req_wdata = d; ls_req_wstrb = s;
    ls_req_valid = 1'b1;
    while (ls_ready_cnt == n0 && t < 100) begin @(posedge clk); #1; t++; end
    if (ls_ready_cnt == n0) check("ls_ready_timeout", 64'(0), 64'(1));
    ls_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((m_busy || pend_v) && t < 200) begin @(posedge clk); #1; t++; end
    if (m_busy || pend_v) check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int n0, r0;
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 64'h0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = 64'h0;
    ls_req_wdata = 64'h0; ls_req_wstrb = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_valid", 64'(axi_ar_valid), 64'(0));
    check("rst_aw_addr",  axi_aw_addr, 64'h0);
    check("rst_if_rsp",   if_rsp_data, 64'h0);
    check("rst_ls_rsp",   64'(ls_rsp_valid), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // IF read: accept N, ar at N+1, rsp at N+3.
    req_if(64'h8000_0000);
    wait_done();
    check("if_ar_latency",  64'(ar_rise_cyc - if_ready_cyc), 64'(1));
    check("if_rsp_latency", 64'(if_rsp_cyc - if_ready_cyc), 64'(3));
    check("if_rsp_data_lit", last_if_data, 64'h1122_3344_5566_7788);
    check("if_no_ls_rsp",   64'(ls_rsp_cnt), 64'(0));

    // LS write with partial strobe, then read back.
    req_ls(1'b1, 64'h8000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    wait_done();
    check("wr_aw_w_same",   64'(aw_rise_cyc), 64'(w_rise_cyc));
    check("wr_aw_latency",  64'(aw_rise_cyc - ls_ready_cyc), 64'(1));
    check("wr_rsp_latency", 64'(ls_rsp_cyc - ls_ready_cyc), 64'(3));
    check("wr_rsp_zero",    last_ls_data, 64'h0);
    check("wr_mem_word",    mem[2], 64'hAAAA_AAAA_DEAD_BEEF);
    req_ls(1'b0, 64'h8000_0010, 64'h0, 8'h0);
    wait_done();
    check("ls_rd_back", last_ls_data, 64'hAAAA_AAAA_DEAD_BEEF);

    // Both requesters held for four grants.
    n0 = grant_log.size();
    if_req_addr = 64'h8000_0000; ls_req_we = 1'b0; ls_req_addr = 64'h8000_0010;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    for (int t = 0; t < 100 && grant_log.size() < n0 + 4; t++) begin @(posedge clk); #1; end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    wait_done();
    check("rr_grant_cnt", 64'(grant_log.size() - n0), 64'(4));
    if (grant_log.size() >= n0 + 4) begin
`ifdef AXI_ARB_LS_PRIO_EN
      check("prio_g0", 64'(grant_log[n0]),   64'(1));
      check("prio_g1", 64'(grant_log[n0+1]), 64'(1));
      check("prio_g2", 64'(grant_log[n0+2]), 64'(1));
      check("prio_g3", 64'(grant_log[n0+3]), 64'(1));
`else
      check("rr_g0", 64'(grant_log[n0]),   64'(0));
      check("rr_g1", 64'(grant_log[n0+1]), 64'(1));
      check("rr_g2", 64'(grant_log[n0+2]), 64'(0));
      check("rr_g3", 64'(grant_log[n0+3]), 64'(1));
`endif
    end

    // ar_ready held off 5 cycles.
    ar_delay = 5;
    req_if(64'h8000_0008);
    wait_done();
    ar_delay = 0;
    check("slow_ar_latency", 64'(if_rsp_cyc - if_ready_cyc), 64'(8));
    check("slow_ar_data",    last_if_data, 64'hA5A5_A5A5_A5A5_A501);

    // Reset while waiting in RD_DATA.
    r_delay = 50;
    r0 = if_rsp_cnt;
    req_if(64'h8000_0018);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_r_ready",  64'(axi_r_ready), 64'(0));
    check("abort_ar_valid", 64'(axi_ar_valid), 64'(0));
    r_delay = 0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(if_rsp_cnt), 64'(r0));
    req_if(64'h8000_0018);
    wait_done();
    check("post_rst_latency", 64'(if_rsp_cyc - if_ready_cyc), 64'(3));
    check("post_rst_data",    last_if_data, 64'hA5A5_A5A5_A5A5_A503);

    // One-cycle LS pulse while an IF read is in flight is dropped.
    n0 = ls_ready_cnt;
    r0 = ls_rsp_cnt;
    req_if(64'h8000_0020);
    ls_req_we = 1'b0; ls_req_addr = 64'h8000_0028; ls_req_valid = 1'b1;
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check("drop_ls_ready", 64'(ls_ready_cnt), 64'(n0));
    check("drop_ls_rsp",   64'(ls_rsp_cnt),   64'(r0));
    check("drop_if_data",  last_if_data, 64'hA5A5_A5A5_A5A5_A504);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
